// File: rtl/reset_sequencer.sv
// Power-on / restart sequencer: synchronizes PLL lock and a bouncing push button,
// holds the SoC in reset for a fixed time and restarts it on lock loss, key press or watchdog expiry.
module reset_sequencer #(
    parameter int HOLD_CYCLES     = 32,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WATCHDOG_CYCLES = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       key_n,
    input  logic       wdt_kick,
    output logic       soc_reset,
    output logic       running,
    output logic [1:0] reset_cause,
    output logic [7:0] reset_count
);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] HOLD      = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;

    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_KEY  = 2'b10;
    localparam logic [1:0] CAUSE_WDT  = 2'b11;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] WDT_LAST  = 32'(WATCHDOG_CYCLES - 1);
    localparam bit          WDT_EN    = (WATCHDOG_CYCLES != 0);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic        lock_p0, lock_p1;
    logic        key_p0, key_p1;
    logic        key_pressed;
    logic [15:0] db_cnt;
    logic        key_accept;

    logic [1:0]  state, state_nx;
    logic [15:0] hold_cnt, hold_nx;
    logic [31:0] wdt_cnt, wdt_nx;
    logic [1:0]  cause_nx;
    logic [7:0]  count_nx;

    // stage p0/p1: two-flop synchronizers for the asynchronous inputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_p0 <= 1'b0;
            lock_p1 <= 1'b0;
            key_p0  <= 1'b0;
            key_p1  <= 1'b0;
        end else begin
            lock_p0 <= pll_locked;
            lock_p1 <= lock_p0;
            key_p0  <= key_n;
            key_p1  <= key_p0;
        end
    end

    // Debounce: a sample equal to key_pressed is a vote for the opposite (pending) level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_pressed <= 1'b0;
            db_cnt      <= '0;
            key_accept  <= 1'b0;
        end else begin
            key_accept <= 1'b0;
            if (key_p1 != key_pressed) begin
                db_cnt <= '0;
            end else if (db_cnt == DEB_LAST) begin
                db_cnt      <= '0;
                key_pressed <= ~key_pressed;
                key_accept  <= ~key_pressed;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        wdt_nx   = '0;
        cause_nx = reset_cause;
        count_nx = reset_count;
        case (state)
            WAIT_LOCK: begin
                if (lock_p1) begin
                    state_nx = HOLD;
                    hold_nx  = '0;
                end
            end
            HOLD: begin
                if (key_accept) begin
                    hold_nx = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nx = RUN;
                    hold_nx  = '0;
                end else begin
                    hold_nx = hold_cnt + 16'd1;
                end
            end
            RUN: begin
                if (key_accept) begin
                    state_nx = HOLD;
                    hold_nx  = '0;
                    cause_nx = CAUSE_KEY;
                end else if (WDT_EN && !wdt_kick && wdt_cnt == WDT_LAST) begin
                    state_nx = HOLD;
                    hold_nx  = '0;
                    cause_nx = CAUSE_WDT;
                end else if (WDT_EN && !wdt_kick) begin
                    wdt_nx = wdt_cnt + 32'd1;
                end
            end
            default: begin
                state_nx = WAIT_LOCK;
                hold_nx  = '0;
            end
        endcase
        // Lock loss overrides every other event, from any state.
        if (!lock_p1) begin
            state_nx = WAIT_LOCK;
            hold_nx  = '0;
            wdt_nx   = '0;
            if (state == RUN) cause_nx = CAUSE_LOCK;
        end
        if (state == RUN && state_nx != RUN) count_nx = sat_inc(reset_count);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= WAIT_LOCK;
            hold_cnt    <= '0;
            wdt_cnt     <= '0;
            reset_cause <= 2'b00;
            reset_count <= 8'd0;
            soc_reset   <= 1'b1;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_nx;
            wdt_cnt     <= wdt_nx;
            reset_cause <= cause_nx;
            reset_count <= count_nx;
            soc_reset   <= (state_nx != RUN);
        end
    end

    assign running = (state == RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected soc_reset/running transitions are queued by
// the stimulus and checked by a monitor whenever the DUT's outputs change.
module tb_reset_sequencer;

    logic       clock;
    logic       reset;
    logic       pll_locked;
    logic       key_n;
    logic       wdt_kick;
    logic       soc_reset;
    logic       running;
    logic [1:0] reset_cause;
    logic [7:0] reset_count;

    reset_sequencer #(
        .HOLD_CYCLES    (16),
        .DEBOUNCE_CYCLES(4),
        .WATCHDOG_CYCLES(64)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pll_locked (pll_locked),
        .key_n      (key_n),
        .wdt_kick   (wdt_kick),
        .soc_reset  (soc_reset),
        .running    (running),
        .reset_cause(reset_cause),
        .reset_count(reset_count)
    );

    typedef struct {
        string      name;
        int         cyc;
        logic       soc;
        logic       run;
        logic [1:0] cause;
        logic [7:0] count;
    } ev_t;

    ev_t  exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic prev_soc = 1'b1;
    logic prev_run = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // cyc holds n after the n-th rising edge
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        @(negedge clock);
        if (soc_reset !== prev_soc || running !== prev_run) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got cyc=%0d soc_reset=%0b running=%0b cause=%0b count=%0d, required no change",
                         cyc, soc_reset, running, reset_cause, reset_count);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (cyc != e.cyc || soc_reset !== e.soc || running !== e.run ||
                    reset_cause !== e.cause || reset_count !== e.count) begin
                    n_fail++;
                    $display("FAIL %s: got cyc=%0d soc_reset=%0b running=%0b cause=%0b count=%0d, required cyc=%0d soc_reset=%0b running=%0b cause=%0b count=%0d",
                             e.name, cyc, soc_reset, running, reset_cause, reset_count,
                             e.cyc, e.soc, e.run, e.cause, e.count);
                end
            end
            prev_soc = soc_reset;
            prev_run = running;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_ev(input string name, input int c, input logic s, input logic r,
                             input logic [1:0] ca, input logic [7:0] co);
        ev_t e;
        e.name = name; e.cyc = c; e.soc = s; e.run = r; e.cause = ca; e.count = co;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drain(input string name, input int maxc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < maxc) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending events after %0d cycles, required 0", name, exp_q.size(), maxc);
            exp_q.delete();
        end
    endtask

    initial begin
        int c;
        int last_kick;
        reset      = 1'b1;
        pll_locked = 1'b0;
        key_n      = 1'b1;
        wdt_kick   = 1'b0;
        last_kick  = 0;

        step(3);
        check("por_soc_reset",   8'(soc_reset),   8'd1);
        check("por_running",     8'(running),     8'd0);
        check("por_cause",       8'(reset_cause), 8'd0);
        check("por_count",       reset_count,     8'd0);
        step(2);
        reset = 1'b0;

        // POR: lock sampled at c+1, HOLD at c+3, RUN 16 cycles later
        step(8);
        c = cyc;
        pll_locked = 1'b1;
        expect_ev("por_run", c + 19, 1'b0, 1'b1, 2'b00, 8'd0);
        drain("por", 40);

        // Bounce: 2-cycle toggling never restarts; steady low restarts once
        for (int i = 0; i < 10; i++) begin
            key_n = 1'b0;
            step(2);
            key_n = 1'b1;
            step(2);
        end
        c = cyc;
        key_n = 1'b0;
        expect_ev("key_restart", c + 7,  1'b1, 1'b0, 2'b10, 8'd1);
        expect_ev("key_run",     c + 23, 1'b0, 1'b1, 2'b10, 8'd1);
        step(10);
        key_n = 1'b1;
        drain("key", 40);

        // Watchdog: 20 kicks 50 cycles apart, then silence
        for (int i = 0; i < 20; i++) begin
            last_kick = cyc;
            wdt_kick = 1'b1;
            step(1);
            wdt_kick = 1'b0;
            step(49);
        end
        expect_ev("wdt_restart", last_kick + 65, 1'b1, 1'b0, 2'b11, 8'd2);
        expect_ev("wdt_run",     last_kick + 81, 1'b0, 1'b1, 2'b11, 8'd2);
        drain("wdt", 100);

        // Synchronized lock falls in the same cycle the key accept fires
        c = cyc;
        key_n = 1'b0;
        step(4);
        pll_locked = 1'b0;
        expect_ev("simul_restart", c + 7, 1'b1, 1'b0, 2'b01, 8'd3);
        step(4);
        key_n = 1'b1;
        step(6);
        c = cyc;
        pll_locked = 1'b1;
        expect_ev("simul_relock_run", c + 19, 1'b0, 1'b1, 2'b01, 8'd3);
        drain("simul", 40);

        // Asynchronous reset in RUN with count=3
        @(posedge clock);
        #2;
        expect_ev("mid_reset", cyc, 1'b1, 1'b0, 2'b00, 8'd0);
        reset = 1'b1;
        #1;
        check("mid_reset_soc_reset", 8'(soc_reset),   8'd1);
        check("mid_reset_running",   8'(running),     8'd0);
        check("mid_reset_cause",     8'(reset_cause), 8'd0);
        check("mid_reset_count",     reset_count,     8'd0);
        pll_locked = 1'b0;
        step(3);
        reset = 1'b0;
        drain("mid_reset", 5);

        // Lock loss at HOLD cycle 5, then a full HOLD after relock
        step(4);
        c = cyc;
        pll_locked = 1'b1;
        step(7);
        pll_locked = 1'b0;
        step(12);
        c = cyc;
        pll_locked = 1'b1;
        expect_ev("hold_lockloss_run", c + 19, 1'b0, 1'b1, 2'b00, 8'd0);
        drain("hold_lockloss", 40);

        step(5);
        check("final_pending_events", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, 32, clock cycles soc_reset is held after lock or a restart event; legal range 2..65535.
REQ-002 Parameter DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples needed to accept a key press; legal range 2..65535.
REQ-003 Parameter WATCHDOG_CYCLES, 0, RUN cycles without a kick before a watchdog restart; 0 disables the watchdog.
REQ-004 The block SHALL have port clock, input, 1, single system clock; all state in this domain.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port pll_locked, input, 1, PLL lock status, asynchronous to clock.
REQ-007 The block SHALL have port key_n, input, 1, push button, active-low, asynchronous and bouncing.
REQ-008 The block SHALL have port wdt_kick, input, 1, single-cycle watchdog refresh pulse from the SoC.
REQ-009 The block SHALL have port soc_reset, output, 1, active-high reset to the SoC, registered.
REQ-010 The block SHALL have port running, output, 1, high while in state RUN.
REQ-011 The block SHALL have port reset_cause, output, 2, cause of the last restart: 00 POR, 01 lock loss, 10 key, 11 watchdog.
REQ-012 The block SHALL have port reset_count, output, 8, number of restarts since POR, saturating at 255.

Function
REQ-013 pll_locked and key_n SHALL each pass through a 2-flop synchronizer before any use; synchronizer latency is 2 cycles.
REQ-014 The FSM SHALL have exactly three states: WAIT_LOCK, HOLD and RUN.
REQ-015 WAIT_LOCK -> HOLD when synchronized lock is 1; the hold counter loads 0 on entry.
REQ-016 HOLD: the hold counter increments each cycle; HOLD -> RUN on the cycle the counter equals HOLD_CYCLES-1, giving exactly HOLD_CYCLES cycles in HOLD.
REQ-017 In any state, synchronized lock = 0 SHALL force WAIT_LOCK; leaving RUN this way sets cause 01.
REQ-018 In RUN, an accepted key press -> HOLD with cause 10; in HOLD, an accepted key press restarts the hold counter at 0 without changing cause.
REQ-019 In RUN with WATCHDOG_CYCLES != 0, the watchdog counter increments each cycle, clears on wdt_kick, and on reaching WATCHDOG_CYCLES-1 without a kick -> HOLD with cause 11.
REQ-020 The watchdog counter SHALL be 0 whenever the state is not RUN.
REQ-021 Priority on simultaneous events SHALL be: lock loss > key press > watchdog expiry; a wdt_kick in the expiry cycle prevents expiry.
REQ-022 Debounce: the synchronized key must read 0 for DEBOUNCE_CYCLES consecutive cycles to produce one accept pulse; no further accept until the key reads 1 for DEBOUNCE_CYCLES consecutive cycles.
REQ-023 Any sample disagreeing with the pending level SHALL clear the debounce counter.
REQ-024 soc_reset SHALL be registered as (next state != RUN), so it falls on the same edge the state becomes RUN and rises on the same edge the state leaves RUN.
REQ-025 running SHALL equal (state == RUN).
REQ-026 reset_count SHALL increment by 1 on every transition out of RUN and hold at 255.

Reset
REQ-027 While reset = 1, the block SHALL force: state WAIT_LOCK, soc_reset 1, running 0, reset_cause 00, reset_count 0, all counters and synchronizer flops 0, and key debounce state "released".
REQ-028 Reset assertion SHALL take effect immediately and asynchronously; deassertion is consumed on the next clock edge with no glitch on soc_reset.
REQ-029 Reset in the middle of HOLD or RUN SHALL discard all progress; there is no retained state.

Verification
All scenarios use HOLD_CYCLES=16, DEBOUNCE_CYCLES=4 and WATCHDOG_CYCLES=64.
REQ-030 POR: release reset, raise pll_locked at cycle 10 -> HOLD at cycle 12, soc_reset falls at cycle 28, running=1, cause=00, count=0.
REQ-031 Bounce: with the system in RUN, key_n toggles 0/1 every 2 cycles for 20 cycles, then holds 0 -> no restart during the toggling; exactly one restart 4+2 cycles after the steady low; soc_reset is high for 16 cycles; cause=10, count=1.
REQ-032 Watchdog: with the system in RUN, kick every 50 cycles -> no restart for 1000 cycles; stop kicking -> soc_reset rises 64 cycles after the last kick; cause=11.
REQ-033 Lock loss during HOLD: drop pll_locked at HOLD cycle 5 -> WAIT_LOCK 2 cycles later; cause and count unchanged; relock -> a full 16-cycle HOLD.
REQ-034 Simultaneous events: drop pll_locked so its synchronized value falls in the same cycle as a key accept -> WAIT_LOCK, cause=01, count incremented by 1 only.
REQ-035 Mid-operation reset: assert reset while in RUN with count=3 -> soc_reset=1 within the same cycle, count=0, cause=00.
